// File: rtl/led_pattern_gen_if.sv
// Control and LED drive bundle for led_pattern_gen.
// bright is present only when LED_PATTERN_PWM_EN is defined.
interface led_pattern_gen_if #(
    parameter int LED_NUM = 6
);
    logic               en;
    logic [1:0]         mode;
    logic [1:0]         speed;
`ifdef LED_PATTERN_PWM_EN
    logic [7:0]         bright;
`endif
    logic [LED_NUM-1:0] leds;
    logic               step_pulse;

`ifdef LED_PATTERN_PWM_EN
    modport master (
        output en, mode, speed, bright,
        input  leds, step_pulse
    );
    modport slave (
        input  en, mode, speed, bright,
        output leds, step_pulse
    );
`else
    modport master (
        output en, mode, speed,
        input  leds, step_pulse
    );
    modport slave (
        input  en, mode, speed,
        output leds, step_pulse
    );
`endif
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern sequencer: step prescaler plus rotate/bounce/fill engine.
// Optional brightness PWM is enabled by defining LED_PATTERN_PWM_EN.
module led_pattern_gen #(
    parameter int LED_NUM     = 6,
    parameter int STEP_CYCLES = 13500000,
    parameter int CNT_W       = 24,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input logic             clk,
    input logic             rst,
    led_pattern_gen_if.slave io
);
    typedef enum logic [1:0] {
        M_ROL  = 2'd0,
        M_ROR  = 2'd1,
        M_BNC  = 2'd2,
        M_FILL = 2'd3
    } mode_e;

    localparam logic [31:0] STEP_W = 32'(STEP_CYCLES);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LED_NUM-1:0] pat_q, pat_d;
    logic               dir_up_q, dir_up_d;
    mode_e              act_q, act_d;
    logic               pulse_q;

    logic [31:0]        limit_w;
    logic [CNT_W-1:0]   limit;
    logic               tick;
    mode_e              mode_in;

    // >= rather than == so a lowered limit fires at once instead of wrapping
    assign limit_w = (STEP_W >> io.speed) - 32'd1;
    assign limit   = limit_w[CNT_W-1:0];
    assign tick    = io.en && (cnt_q >= limit);
    assign mode_in = mode_e'(io.mode);

    always_comb begin
        cnt_d    = cnt_q;
        pat_d    = pat_q;
        dir_up_d = dir_up_q;
        act_d    = act_q;
        if (io.en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
        if (tick) begin
            if (mode_in != act_q) begin
                act_d    = mode_in;
                pat_d    = LED_NUM'(1);
                dir_up_d = 1'b1;
            end else begin
                unique case (act_q)
                    M_ROL: pat_d = {pat_q[LED_NUM-2:0], pat_q[LED_NUM-1]};
                    M_ROR: pat_d = {pat_q[0], pat_q[LED_NUM-1:1]};
                    M_BNC: begin
                        if (dir_up_q) begin
                            if (pat_q[LED_NUM-1]) begin
                                dir_up_d = 1'b0;
                                pat_d    = pat_q >> 1;
                            end else begin
                                pat_d = pat_q << 1;
                            end
                        end else begin
                            if (pat_q[0]) begin
                                dir_up_d = 1'b1;
                                pat_d    = pat_q << 1;
                            end else begin
                                pat_d = pat_q >> 1;
                            end
                        end
                    end
                    M_FILL: begin
                        if (&pat_q) pat_d = '0;
                        else        pat_d = {pat_q[LED_NUM-2:0], 1'b1};
                    end
                    default: pat_d = pat_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            pat_q    <= LED_NUM'(1);
            dir_up_q <= 1'b1;
            act_q    <= M_ROL;
            pulse_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pat_q    <= pat_d;
            dir_up_q <= dir_up_d;
            act_q    <= act_d;
            pulse_q  <= tick;
        end
    end

    logic [LED_NUM-1:0] lit;

`ifdef LED_PATTERN_PWM_EN
    logic [7:0] pwm_q;

    always_ff @(posedge clk) begin
        if (rst) pwm_q <= '0;
        else     pwm_q <= pwm_q + 8'd1;
    end

    assign lit = pat_q & {LED_NUM{(pwm_q < io.bright)}};
`else
    assign lit = pat_q;
`endif

    assign io.leds       = lit ^ {LED_NUM{ACTIVE_LOW}};
    assign io.step_pulse = pulse_q;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen (LED_NUM=4, STEP_CYCLES=16).
module tb_led_pattern_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [1:0] speed = 2'd0;
    logic [7:0] bright = 8'd255;
    logic [7:0] pwm_m;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    led_pattern_gen_if #(.LED_NUM(4)) bus_h ();
    led_pattern_gen_if #(.LED_NUM(4)) bus_l ();

    assign bus_h.en    = en;
    assign bus_h.mode  = mode;
    assign bus_h.speed = speed;
    assign bus_l.en    = en;
    assign bus_l.mode  = mode;
    assign bus_l.speed = speed;
`ifdef LED_PATTERN_PWM_EN
    assign bus_h.bright = bright;
    assign bus_l.bright = bright;
`endif

    led_pattern_gen #(
        .LED_NUM(4), .STEP_CYCLES(16), .CNT_W(5), .ACTIVE_LOW(1'b0)
    ) dut_h (
        .clk(clk), .rst(rst), .io(bus_h)
    );

    led_pattern_gen #(
        .LED_NUM(4), .STEP_CYCLES(16), .CNT_W(5), .ACTIVE_LOW(1'b1)
    ) dut_l (
        .clk(clk), .rst(rst), .io(bus_l)
    );

    // reference brightness counter, free-running like the design's
    always @(posedge clk) pwm_m <= rst ? 8'd0 : pwm_m + 8'd1;

    function automatic logic [3:0] exp_leds(input logic [3:0] pat);
`ifdef LED_PATTERN_PWM_EN
        return (pwm_m < bright) ? pat : 4'b0000;
`else
        return pat;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int maxc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus_h.step_pulse && n < maxc);
    endtask

    task automatic pulse_chk(input string tag, input int gap,
                             input logic [3:0] pat);
        int n;
        wait_pulse(64, n);
        chk({tag, "_gap"}, n, gap);
        chk(tag, {28'd0, bus_h.leds}, {28'd0, exp_leds(pat)});
    endtask

    initial begin
        int bad;
        int on_lit, on_dark;
        logic [3:0] held;

        repeat (3) step();
        chk("rst_leds_hi", {28'd0, bus_h.leds}, {28'd0, exp_leds(4'b0001)});
        chk("rst_pulse", {31'd0, bus_h.step_pulse}, 32'd0);
        chk("rst_leds_lo", {28'd0, bus_l.leds},
            {28'd0, exp_leds(4'b0001) ^ 4'b1111});
        rst = 1'b0;

        // rotate-left
        pulse_chk("rol1", 16, 4'b0010);
        pulse_chk("rol2", 16, 4'b0100);
        pulse_chk("rol3", 16, 4'b1000);
        pulse_chk("rol4", 16, 4'b0001);

        // bounce
        mode = 2'd2;
        pulse_chk("bnc_ld", 16, 4'b0001);
        pulse_chk("bnc1", 16, 4'b0010);
        pulse_chk("bnc2", 16, 4'b0100);
        pulse_chk("bnc3", 16, 4'b1000);
        pulse_chk("bnc4", 16, 4'b0100);
        pulse_chk("bnc5", 16, 4'b0010);
        pulse_chk("bnc6", 16, 4'b0001);
        pulse_chk("bnc7", 16, 4'b0010);

        // fill
        mode = 2'd3;
        pulse_chk("fil_ld", 16, 4'b0001);
        pulse_chk("fil1", 16, 4'b0011);
        pulse_chk("fil2", 16, 4'b0111);
        pulse_chk("fil3", 16, 4'b1111);
        pulse_chk("fil4", 16, 4'b0000);
        pulse_chk("fil5", 16, 4'b0001);

        // mode change mid-step waits for the tick, which only reloads
        repeat (5) step();
        mode = 2'd1;
        step();
        chk("midstep", {28'd0, bus_h.leds}, {28'd0, exp_leds(4'b0001)});
        pulse_chk("ror_ld", 10, 4'b0001);
        pulse_chk("ror1", 16, 4'b1000);

        // speed drop with cnt past new limit
        repeat (10) step();
        speed = 2'd2;
        pulse_chk("spd_now", 1, 4'b0100);
        pulse_chk("spd_gap", 4, 4'b0010);

        // pause holds everything
        repeat (2) step();
        en = 1'b0;
        bad = 0;
        repeat (50) begin
            step();
            if (bus_h.step_pulse || bus_h.leds !== exp_leds(4'b0010)) bad++;
        end
        chk("pause", bad, 0);
        en = 1'b1;
        pulse_chk("resume", 2, 4'b0001);
        pulse_chk("ror2", 4, 4'b1000);

        // reset coincident with a tick wins
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("rst_tick_leds", {28'd0, bus_h.leds}, {28'd0, exp_leds(4'b0001)});
        chk("rst_tick_pulse", {31'd0, bus_h.step_pulse}, 32'd0);
        chk("rst_lo", {28'd0, bus_l.leds},
            {28'd0, exp_leds(4'b0001) ^ 4'b1111});
        speed = 2'd0;
        rst = 1'b0;
        pulse_chk("post_rst_ld", 16, 4'b0001);
        pulse_chk("post_rst1", 16, 4'b1000);

`ifdef LED_PATTERN_PWM_EN
        en = 1'b0;
        bright = 8'd64;
        on_lit = 0;
        on_dark = 0;
        repeat (256) begin
            step();
            if (bus_h.leds[3]) on_lit++;
            if (bus_h.leds[0]) on_dark++;
        end
        chk("pwm64_lit", on_lit, 64);
        chk("pwm64_dark", on_dark, 0);
        bright = 8'd0;
        bad = 0;
        repeat (256) begin
            step();
            if (bus_h.leds != 4'b0000) bad++;
            if (bus_l.leds != 4'b1111) bad++;
        end
        chk("pwm0", bad, 0);
`else
        on_lit = 0;
        on_dark = 0;
        held = 4'b0000;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
